avalon_mem_bist_master: RTL and testbench
=========================================

Name: avalon_mem_bist_master

Overview:
- Avalon-MM initiator that drives the word-addressed, single-port on-chip memory slave used by the Nios system.
- On `start`, it fills a region of memory with a 32-bit LFSR pattern, reads the region back in pipelined fashion, and compares each word against the regenerated pattern.
- It reports pass/fail, the error count and the first failing address.
- It is used for memory self-test at boot and under software control, and sits beside the CPU on the same interconnect.

Parameters:
- ADDR_W, 13, word-address width of the target slave.
- DATA_W, 32, data width; byteenable is DATA_W/8 bits.
- READ_LATENCY, 1, fixed cycles from an accepted read to valid av_readdata; legal range 1..4.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; ignored while busy.
- base_addr  in  ADDR_W  first word address; sampled on an accepted start.
- word_count  in  ADDR_W+1  number of words to test (0..2^ADDR_W); sampled on an accepted start.
- seed  in  32  LFSR seed; sampled on an accepted start; 0 is replaced by 1.
- busy  out  1  high while a test runs.
- done  out  1  one-cycle pulse at the end of a test.
- pass  out  1  1 if error_count==0; held until the next accepted start.
- error_count  out  16  number of mismatched words; saturates at 0xFFFF.
- first_fail_addr  out  ADDR_W  address of the first mismatch; 0 if none.
- av_address  out  ADDR_W  word address.
- av_chipselect  out  1  asserted for every read and write command.
- av_write  out  1  write command.
- av_read  out  1  read command.
- av_byteenable  out  DATA_W/8  all ones during commands; 0 otherwise.
- av_writedata  out  DATA_W  pattern word.
- av_readdata  in  DATA_W  slave read data.
- av_waitrequest  in  1  slave stall; tie to 0 for on-chip RAM.

Behaviour:
- Reset (async assert, sync release): state IDLE; every output 0; internal counters and pipelines cleared.
- Reset mid-test aborts the test immediately. No done pulse is produced and bus signals drop in the same cycle as the reset assertion.
- LFSR: next = {s[30:0], s[31]^s[21]^s[1]^s[0]}. Word i uses the LFSR state after i steps from the seed, so word 0 = seed.
- Addressing: address i = (base_addr + i) mod 2^ADDR_W; the address wraps silently.
- A command is "accepted" in a cycle where chipselect=1 and av_waitrequest=0. Address, index and LFSR advance only on acceptance; command signals and data are held stable while stalled.
- IDLE:
  - busy=0.
  - On start: latch inputs; clear error_count and first_fail_addr; set pass=0.
  - If word_count==0, go to DONE; otherwise go to WRITE.
- WRITE:
  - chipselect=1, write=1, writedata = pattern.
  - After the word_count-th accepted write, go to READ (next cycle, no gap).
  - Re-seed the read-side LFSR from the latched seed.
- READ:
  - chipselect=1, read=1; one read per accepted cycle.
  - Each accepted read pushes {expected pattern, address} into a valid-tagged delay line READ_LATENCY deep.
  - After the last accepted read, go to DRAIN.
- Compare:
  - Applies in READ and DRAIN: when the delay-line output is valid, compare av_readdata with expected.
  - On mismatch: increment error_count (saturating). If this is the first mismatch, capture its address into first_fail_addr.
- DRAIN: no commands issued. Once the delay line is empty (all valid bits clear), go to DONE.
- DONE:
  - done=1 for one cycle.
  - pass = (error_count==0), using the final count including the last compare.
  - busy=0 in this cycle; return to IDLE.
- Timing with no stalls:
  - start sampled at edge 0.
  - Writes occupy cycles 1..N; reads occupy cycles N+1..2N.
  - done is high in cycle 2N+READ_LATENCY+1.
  - busy is high in cycles 1..2N+READ_LATENCY.
- word_count==0: done is high in cycle 1, pass=1, and no bus activity occurs.
- start while busy, or in the DONE cycle, is ignored.

Test Plan:
- base=0x0100, N=4, seed=1, ideal RAM with latency 1, no stalls -> writedata 0x1, 0x3, 0x6, 0xD at 0x100..0x103; done in cycle 10; pass=1; error_count=0.
- Same run with the RAM model flipping bit 0 of the word at 0x102 on read -> error_count=1; first_fail_addr=0x102; pass=0.
- Two mismatches at 0x101 and 0x103 -> error_count=2; first_fail_addr=0x101.
- N=8 with random av_waitrequest (~40%) -> writes and reads hold their address and data while stalled; same pattern stored; pass=1; no dropped or duplicated transfers.
- base=0x1FFE, N=4 -> addresses issued in order 0x1FFE, 0x1FFF, 0x0000, 0x0001; pass=1.
- word_count=0 -> done in cycle 1, pass=1, chipselect never asserted.
- Assert reset_n low mid-WRITE -> all outputs 0 immediately; after release, a new start with N=2 completes normally with pass=1.

Source files
------------

// File: rtl/avalon_mem_bist_master.sv
// avalon_mem_bist_master
//   Avalon-MM initiator for memory self-test. On an accepted start it writes
//   a 32-bit LFSR pattern over word_count words beginning at base_addr.
//   It then reads the same region back with pipelined reads and compares
//   each returned word against the regenerated pattern. The result is
//   reported through pass, error_count and first_fail_addr.
//
// Ports
//   clk, reset_n        clock (rising edge), async active-low reset
//   start               one-cycle request, ignored unless idle
//   base_addr           first word address (latched on accepted start)
//   word_count          number of words, 0..2^ADDR_W (latched on start)
//   seed                LFSR seed, 0 is replaced by 1 (latched on start)
//   busy, done          test running / one-cycle end-of-test pulse
//   pass                error_count==0 at the end; held until next start
//   error_count         saturating mismatch count
//   first_fail_addr     address of the first mismatch, 0 if none
//   av_*                Avalon-MM initiator signals (word addressed)
module avalon_mem_bist_master #(
    parameter int ADDR_W       = 13,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W:0]       word_count,
    input  logic [31:0]           seed,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [15:0]           error_count,
    output logic [ADDR_W-1:0]     first_fail_addr,
    output logic [ADDR_W-1:0]     av_address,
    output logic                  av_chipselect,
    output logic                  av_write,
    output logic                  av_read,
    output logic [DATA_W/8-1:0]   av_byteenable,
    output logic [DATA_W-1:0]     av_writedata,
    input  logic [DATA_W-1:0]     av_readdata,
    input  logic                  av_waitrequest
);

    localparam logic [ADDR_W:0]     IDX_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0]   ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W/8-1:0] BE_ALL   = {(DATA_W/8){1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // One step of the 32-bit pattern generator.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    state_t                  state_r;
    logic [ADDR_W-1:0]       base_r;
    logic [ADDR_W:0]         count_r;
    logic [ADDR_W:0]         idx_r;
    logic [31:0]             seed_r;
    logic [31:0]             lfsr_r;      // pattern of the command currently on the bus

    // Delay line aligning each accepted read with its returning data.
    logic [READ_LATENCY-1:0] dl_valid_r;
    logic [31:0]             dl_exp_r  [READ_LATENCY];
    logic [ADDR_W-1:0]       dl_addr_r [READ_LATENCY];

    logic [31:0]             seed_eff_s;
    logic                    accept_s;
    logic [ADDR_W:0]         idx_inc_s;
    logic                    last_s;
    logic                    push_s;
    logic                    cmp_valid_s;
    logic                    mismatch_s;
    logic [READ_LATENCY-1:0] pending_s;
    logic [15:0]             err_next_s;
    logic [ADDR_W-1:0]       fail_addr_next_s;

    assign seed_eff_s  = (seed == 32'd0) ? 32'd1 : seed;
    assign accept_s    = av_chipselect & ~av_waitrequest;
    assign idx_inc_s   = idx_r + IDX_ONE;
    assign last_s      = (idx_inc_s == count_r);
    assign push_s      = (state_r == ST_READ) && accept_s;
    assign cmp_valid_s = dl_valid_r[READ_LATENCY-1];
    assign mismatch_s  = cmp_valid_s &&
                         (av_readdata != DATA_W'(dl_exp_r[READ_LATENCY-1]));
    // Valid bits that will still be in flight after this cycle's shift
    // (the last stage drops out; nothing is pushed while draining).
    assign pending_s   = dl_valid_r << 1'b1;

    // Next error count and first-fail address from this cycle's compare.
    always_comb begin
        err_next_s       = error_count;
        fail_addr_next_s = first_fail_addr;
        if (mismatch_s) begin
            if (error_count != 16'hFFFF) begin
                err_next_s = error_count + 16'd1;
            end else begin
                err_next_s = error_count;
            end
            // The count never wraps back to zero, so zero means no earlier miss.
            if (error_count == 16'd0) begin
                fail_addr_next_s = dl_addr_r[READ_LATENCY-1];
            end else begin
                fail_addr_next_s = first_fail_addr;
            end
        end else begin
            err_next_s       = error_count;
            fail_addr_next_s = first_fail_addr;
        end
    end

    // Read-expectation delay line: shifts every cycle, loads on accepted reads.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dl_valid_r <= {READ_LATENCY{1'b0}};
            for (int k = 0; k < READ_LATENCY; k++) begin
                dl_exp_r[k]  <= 32'd0;
                dl_addr_r[k] <= {ADDR_W{1'b0}};
            end
        end else begin
            dl_valid_r   <= {dl_valid_r, push_s};
            dl_exp_r[0]  <= lfsr_r;
            dl_addr_r[0] <= av_address;
            for (int k = 1; k < READ_LATENCY; k++) begin
                dl_exp_r[k]  <= dl_exp_r[k-1];
                dl_addr_r[k] <= dl_addr_r[k-1];
            end
        end
    end

    // Test sequencer with registered bus and status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r         <= ST_IDLE;
            base_r          <= {ADDR_W{1'b0}};
            count_r         <= {(ADDR_W+1){1'b0}};
            idx_r           <= {(ADDR_W+1){1'b0}};
            seed_r          <= 32'd0;
            lfsr_r          <= 32'd0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            error_count     <= 16'd0;
            first_fail_addr <= {ADDR_W{1'b0}};
            av_address      <= {ADDR_W{1'b0}};
            av_chipselect   <= 1'b0;
            av_write        <= 1'b0;
            av_read         <= 1'b0;
            av_byteenable   <= {(DATA_W/8){1'b0}};
            av_writedata    <= {DATA_W{1'b0}};
        end else begin
            error_count     <= err_next_s;
            first_fail_addr <= fail_addr_next_s;
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        base_r          <= base_addr;
                        count_r         <= word_count;
                        seed_r          <= seed_eff_s;
                        lfsr_r          <= seed_eff_s;
                        idx_r           <= {(ADDR_W+1){1'b0}};
                        error_count     <= 16'd0;
                        first_fail_addr <= {ADDR_W{1'b0}};
                        if (word_count == {(ADDR_W+1){1'b0}}) begin
                            state_r <= ST_DONE;
                            done    <= 1'b1;
                            pass    <= 1'b1;
                        end else begin
                            state_r       <= ST_WRITE;
                            busy          <= 1'b1;
                            pass          <= 1'b0;
                            av_chipselect <= 1'b1;
                            av_write      <= 1'b1;
                            av_byteenable <= BE_ALL;
                            av_address    <= base_addr;
                            av_writedata  <= DATA_W'(seed_eff_s);
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    if (accept_s) begin
                        if (last_s) begin
                            // Restart the pattern from the seed for the read pass.
                            state_r      <= ST_READ;
                            idx_r        <= {(ADDR_W+1){1'b0}};
                            av_write     <= 1'b0;
                            av_read      <= 1'b1;
                            av_address   <= base_r;
                            av_writedata <= {DATA_W{1'b0}};
                            lfsr_r       <= seed_r;
                        end else begin
                            idx_r        <= idx_inc_s;
                            av_address   <= av_address + ADDR_ONE;
                            lfsr_r       <= lfsr_next(lfsr_r);
                            av_writedata <= DATA_W'(lfsr_next(lfsr_r));
                        end
                    end else begin
                        state_r <= ST_WRITE;
                    end
                end
                ST_READ: begin
                    if (accept_s) begin
                        if (last_s) begin
                            state_r       <= ST_DRAIN;
                            idx_r         <= {(ADDR_W+1){1'b0}};
                            av_chipselect <= 1'b0;
                            av_read       <= 1'b0;
                            av_byteenable <= {(DATA_W/8){1'b0}};
                            av_address    <= {ADDR_W{1'b0}};
                        end else begin
                            idx_r      <= idx_inc_s;
                            av_address <= av_address + ADDR_ONE;
                            lfsr_r     <= lfsr_next(lfsr_r);
                        end
                    end else begin
                        state_r <= ST_READ;
                    end
                end
                ST_DRAIN: begin
                    if (pending_s == {READ_LATENCY{1'b0}}) begin
                        state_r <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= (err_next_s == 16'd0);
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    done    <= 1'b0;
                end
                default: begin
                    state_r       <= ST_IDLE;
                    busy          <= 1'b0;
                    done          <= 1'b0;
                    av_chipselect <= 1'b0;
                    av_write      <= 1'b0;
                    av_read       <= 1'b0;
                    av_byteenable <= {(DATA_W/8){1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_avalon_mem_bist_master.sv
module tb_avalon_mem_bist_master;
    localparam int AW = 13;
    localparam int DW = 32;
    localparam int MEMSZ = 8192;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   word_count;
    logic [31:0]   seed;
    logic          busy, done, pass;
    logic [15:0]   error_count;
    logic [AW-1:0] first_fail_addr;
    logic [AW-1:0] av_address;
    logic          av_chipselect, av_write, av_read;
    logic [DW/8-1:0] av_byteenable;
    logic [DW-1:0] av_writedata;
    logic [DW-1:0] av_readdata;
    logic          av_waitrequest;

    always #5 clk = ~clk;

    avalon_mem_bist_master #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(1)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .word_count(word_count), .seed(seed), .busy(busy), .done(done),
        .pass(pass), .error_count(error_count), .first_fail_addr(first_fail_addr),
        .av_address(av_address), .av_chipselect(av_chipselect), .av_write(av_write),
        .av_read(av_read), .av_byteenable(av_byteenable), .av_writedata(av_writedata),
        .av_readdata(av_readdata), .av_waitrequest(av_waitrequest)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // Slave memory model; flip_mem XORs a mask into read data to plant errors.
    logic [31:0] mem [MEMSZ];
    logic [31:0] flip_mem [MEMSZ];

    logic [AW-1:0] wlog_a[$];
    logic [31:0]   wlog_d[$];
    logic [AW-1:0] rlog_a[$];
    int            done_cyc, busy_cnt, hold_err, any_cs;
    logic          busy_at_done, post_activity, pass_held;
    logic          res_pass;
    logic [15:0]   res_err;
    logic [AW-1:0] res_ffa;

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_pattern(input logic [31:0] s0, input int i);
        logic [31:0] s;
        logic        fb;
        s = (s0 == 32'd0) ? 32'd1 : s0;
        for (int k = 0; k < i; k++) begin
            fb = s[31] ^ s[21] ^ s[1] ^ s[0];
            s = (s << 1) | {31'd0, fb};
        end
        return s;
    endfunction

    function automatic logic [AW-1:0] ref_addr(input logic [AW-1:0] b, input int i);
        return AW'((int'(b) + i) % MEMSZ);
    endfunction

    function automatic int ref_errors(input logic [AW-1:0] b, input int n);
        int c = 0;
        for (int i = 0; i < n; i++) if (flip_mem[ref_addr(b, i)] != 32'd0) c++;
        return (c > 65535) ? 65535 : c;
    endfunction

    function automatic logic [AW-1:0] ref_ffa(input logic [AW-1:0] b, input int n);
        for (int i = 0; i < n; i++) if (flip_mem[ref_addr(b, i)] != 32'd0) return ref_addr(b, i);
        return '0;
    endfunction

    // Number of logged transfers / stored words deviating from the reference lists.
    function automatic int seq_diffs(input logic [AW-1:0] b, input int n, input logic [31:0] s);
        int d = 0;
        if (wlog_a.size() != n || rlog_a.size() != n) d++;
        for (int i = 0; i < n && i < wlog_a.size(); i++)
            if (wlog_a[i] !== ref_addr(b, i) || wlog_d[i] !== ref_pattern(s, i)) d++;
        for (int i = 0; i < n && i < rlog_a.size(); i++)
            if (rlog_a[i] !== ref_addr(b, i)) d++;
        for (int i = 0; i < n; i++)
            if (mem[ref_addr(b, i)] !== ref_pattern(s, i)) d++;
        return d;
    endfunction

    function automatic logic outputs_nonzero();
        return |{busy, done, pass, error_count, first_fail_addr, av_address,
                 av_chipselect, av_write, av_read, av_byteenable, av_writedata};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < MEMSZ; i++) begin
            mem[i] = 32'd0;
            flip_mem[i] = 32'd0;
        end
    endtask

    // ---------------- stimulus driver + slave ----------------
    task automatic do_run(input logic [AW-1:0] b, input logic [AW:0] n, input logic [31:0] s,
                          input int stall_pct, input bit poke);
        bit            stalled, pend_v;
        logic [31:0]   pend_d;
        logic [AW+34:0] snap;
        int            cyc;
        wlog_a.delete(); wlog_d.delete(); rlog_a.delete();
        done_cyc = -1; busy_cnt = 0; hold_err = 0; any_cs = 0; busy_at_done = 1'b0;
        res_pass = 1'b0; res_err = 16'd0; res_ffa = '0;
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; word_count = n; seed = s; av_waitrequest = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; base_addr = AW'($urandom); word_count = (AW+1)'($urandom); seed = $urandom;
        cyc = 1; stalled = 0; pend_v = 0; pend_d = 32'd0;
        while (cyc <= 600 && done_cyc < 0) begin
            av_readdata = pend_v ? pend_d : $urandom;
            pend_v = 0;
            av_waitrequest = ($urandom_range(0, 99) < stall_pct);
            if (stalled && {av_chipselect, av_write, av_read, av_address, av_writedata} !== snap)
                hold_err++;
            if (av_chipselect) any_cs++;
            if (busy) busy_cnt++;
            stalled = av_chipselect && av_waitrequest;
            snap = {av_chipselect, av_write, av_read, av_address, av_writedata};
            if (av_chipselect && !av_waitrequest) begin
                if (av_write) begin
                    wlog_a.push_back(av_address);
                    wlog_d.push_back(av_writedata);
                    mem[av_address] = av_writedata;
                end
                if (av_read) begin
                    rlog_a.push_back(av_address);
                    pend_v = 1;
                    pend_d = mem[av_address] ^ flip_mem[av_address];
                end
            end
            if (done) begin
                done_cyc = cyc; busy_at_done = busy;
                res_pass = pass; res_err = error_count; res_ffa = first_fail_addr;
            end
            // Requests while busy or in the done cycle must be ignored.
            start = poke && (cyc == 2 || done);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0; av_waitrequest = 1'b0;
        post_activity = busy | av_chipselect;
        pass_held = (pass === res_pass);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; base_addr = '0; word_count = '0; seed = 32'd0;
        av_readdata = 32'd0; av_waitrequest = 1'b0;
        #1;
        n_cmp++;
        if (outputs_nonzero() !== 1'b0) begin
            n_fail++; $display("FAIL reset_async_outputs: got nonzero, want all 0");
        end
        repeat (3) @(posedge clk);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (outputs_nonzero() !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle_outputs: got nonzero, want all 0");
        end
    endtask

    task automatic test_basic();
        clear_mem();
        do_run(13'h0100, 14'd4, 32'd1, 0, 1'b0);
        n_cmp++;
        if (wlog_d.size() != 4 || wlog_d[0] !== 32'h1 || wlog_d[1] !== 32'h3 ||
            wlog_d[2] !== 32'h6 || wlog_d[3] !== 32'hD) begin
            n_fail++; $display("FAIL basic_writedata: got %0d writes first=%h, want 1,3,6,D",
                               wlog_d.size(), (wlog_d.size() > 0) ? wlog_d[0] : 32'hx);
        end
        n_cmp++;
        if (seq_diffs(13'h0100, 4, 32'd1) !== 0) begin
            n_fail++; $display("FAIL basic_sequence: got %0d diffs, want 0", seq_diffs(13'h0100, 4, 32'd1));
        end
        n_cmp++;
        if (done_cyc !== 10) begin
            n_fail++; $display("FAIL basic_done_cycle: got %0d, want 10", done_cyc);
        end
        n_cmp++;
        if (busy_cnt !== 9 || busy_at_done !== 1'b0) begin
            n_fail++; $display("FAIL basic_busy: got %0d cycles busy_at_done=%b, want 9 and 0",
                               busy_cnt, busy_at_done);
        end
        n_cmp++;
        if (res_pass !== 1'b1 || res_err !== 16'd0 || !pass_held) begin
            n_fail++; $display("FAIL basic_result: got pass=%b err=%0d held=%b, want 1 0 1",
                               res_pass, res_err, pass_held);
        end
    endtask

    task automatic test_single_error();
        clear_mem();
        flip_mem[13'h102] = 32'h1;
        do_run(13'h0100, 14'd4, 32'd1, 0, 1'b0);
        n_cmp++;
        if (res_err !== 16'd1 || res_ffa !== 13'h102 || res_pass !== 1'b0) begin
            n_fail++; $display("FAIL single_error: got err=%0d ffa=%h pass=%b, want 1 102 0",
                               res_err, res_ffa, res_pass);
        end
    endtask

    task automatic test_two_errors();
        clear_mem();
        flip_mem[13'h101] = 32'h8000_0000;
        flip_mem[13'h103] = 32'h0000_0100;
        do_run(13'h0100, 14'd4, 32'd1, 0, 1'b0);
        n_cmp++;
        if (res_err !== 16'd2 || res_ffa !== 13'h101 || res_pass !== 1'b0) begin
            n_fail++; $display("FAIL two_errors: got err=%0d ffa=%h pass=%b, want 2 101 0",
                               res_err, res_ffa, res_pass);
        end
    endtask

    task automatic test_stall();
        logic [31:0] s;
        logic [AW-1:0] b;
        s = $urandom; b = AW'($urandom);
        clear_mem();
        do_run(b, 14'd8, s, 40, 1'b1);
        n_cmp++;
        if (hold_err !== 0) begin
            n_fail++; $display("FAIL stall_hold: got %0d changes while stalled, want 0", hold_err);
        end
        n_cmp++;
        if (seq_diffs(b, 8, s) !== 0) begin
            n_fail++; $display("FAIL stall_sequence: got %0d diffs, want 0", seq_diffs(b, 8, s));
        end
        n_cmp++;
        if (res_pass !== 1'b1 || res_err !== 16'd0 || done_cyc < 18) begin
            n_fail++; $display("FAIL stall_result: got pass=%b err=%0d done=%0d, want 1 0 >=18",
                               res_pass, res_err, done_cyc);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] s;
        s = $urandom;
        clear_mem();
        do_run(13'h1FFE, 14'd4, s, 0, 1'b0);
        n_cmp++;
        if (wlog_a.size() != 4 || wlog_a[0] !== 13'h1FFE || wlog_a[1] !== 13'h1FFF ||
            wlog_a[2] !== 13'h0000 || wlog_a[3] !== 13'h0001) begin
            n_fail++; $display("FAIL wrap_addresses: got %0d writes first=%h, want 1FFE,1FFF,0,1",
                               wlog_a.size(), (wlog_a.size() > 0) ? wlog_a[0] : 13'hx);
        end
        n_cmp++;
        if (seq_diffs(13'h1FFE, 4, s) !== 0 || res_pass !== 1'b1) begin
            n_fail++; $display("FAIL wrap_result: got diffs=%0d pass=%b, want 0 1",
                               seq_diffs(13'h1FFE, 4, s), res_pass);
        end
    endtask

    task automatic test_zero_count();
        clear_mem();
        do_run(13'h0055, 14'd0, $urandom, 0, 1'b1);
        n_cmp++;
        if (done_cyc !== 1 || res_pass !== 1'b1 || any_cs !== 0 || busy_cnt !== 0) begin
            n_fail++; $display("FAIL zero_count: got done=%0d pass=%b cs=%0d busy=%0d, want 1 1 0 0",
                               done_cyc, res_pass, any_cs, busy_cnt);
        end
        n_cmp++;
        if (post_activity !== 1'b0) begin
            n_fail++; $display("FAIL zero_count_start_in_done: got activity=%b, want 0", post_activity);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] s;
        clear_mem();
        @(posedge clk); #1;
        start = 1'b1; base_addr = 13'h0040; word_count = 14'd8; seed = $urandom | 32'd1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (av_chipselect !== 1'b1 || av_write !== 1'b1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid_precondition: got cs=%b wr=%b busy=%b, want 1 1 1",
                               av_chipselect, av_write, busy);
        end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if (outputs_nonzero() !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_outputs: got nonzero, want all 0");
        end
        repeat (2) @(posedge clk);
        n_cmp++;
        if (done !== 1'b0 || outputs_nonzero() !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_held: got done=%b, want all 0", done);
        end
        @(negedge clk); reset_n = 1'b1;
        s = $urandom;
        clear_mem();
        do_run(13'h0020, 14'd2, s, 0, 1'b0);
        n_cmp++;
        if (res_pass !== 1'b1 || done_cyc !== 6 || seq_diffs(13'h0020, 2, s) !== 0) begin
            n_fail++; $display("FAIL reset_mid_rerun: got pass=%b done=%0d, want 1 6", res_pass, done_cyc);
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] b;
        int            n;
        logic [31:0]   s;
        for (int it = 0; it < 8; it++) begin
            b = AW'($urandom_range(0, MEMSZ - 1));
            n = $urandom_range(1, 24);
            s = (it == 0) ? 32'd0 : $urandom;
            clear_mem();
            for (int i = 0; i < n; i++)
                if ($urandom_range(0, 3) == 0) flip_mem[ref_addr(b, i)] = 32'd1 << $urandom_range(0, 31);
            do_run(b, (AW+1)'(n), s, $urandom_range(0, 50), it[0]);
            n_cmp++;
            if (res_err !== 16'(ref_errors(b, n)) || res_ffa !== ref_ffa(b, n) ||
                res_pass !== (ref_errors(b, n) == 0) || !pass_held) begin
                n_fail++; $display("FAIL random_%0d_result: got err=%0d ffa=%h pass=%b, want %0d %h %b",
                                   it, res_err, res_ffa, res_pass, ref_errors(b, n), ref_ffa(b, n),
                                   ref_errors(b, n) == 0);
            end
            n_cmp++;
            if (seq_diffs(b, n, s) !== 0 || hold_err !== 0 || post_activity !== 1'b0) begin
                n_fail++; $display("FAIL random_%0d_bus: got diffs=%0d hold=%0d post=%b, want 0 0 0",
                                   it, seq_diffs(b, n, s), hold_err, post_activity);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single_error();
        test_two_errors();
        test_stall();
        test_wrap();
        test_zero_count();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
